// File: rtl/regfile_multiport_if.sv
// -----------------------------------------------------------------------------
// regfile_multiport_if
// Bus bundle between the pipeline and the multi-port integer register file.
//   master : decode/writeback side (drives read/write/clear requests)
//   slave  : register file side
// Signals:
//   rd_en    [NRD]       per-port read enable
//   rd_addr  [NRD*AW]    read addresses, port i at [i*AW +: AW]
//   rd_data  [NRD*XLEN]  registered read data, port i at [i*XLEN +: XLEN]
//   wr_en / wr_addr / wr_data   single write port
//   clr_req  full-file clear request
//   clr_busy clear in progress (writes ignored)
//   clr_done one-cycle pulse at the end of a clear
// -----------------------------------------------------------------------------
interface regfile_multiport_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                clr_req;
    logic                clr_busy;
    logic                clr_done;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, clr_busy, clr_done
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, clr_busy, clr_done
    );
endinterface

// File: rtl/regfile_multiport.sv
// -----------------------------------------------------------------------------
// regfile_multiport
// Parametrised RISC-V integer register file: NRD registered read ports, one
// write port, x0 hardwired to zero, and a clear sequencer that zeroes
// x1..x(NREG-1) one register per cycle.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous, active-low reset (clears all state and storage)
//   bus  regfile_multiport_if.slave (read ports, write port, clear handshake)
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read that hits the register being
//                      written (or cleared) in the same cycle returns the new
//                      value; otherwise reads return the old value.
// -----------------------------------------------------------------------------
module regfile_multiport #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) (
    input  logic               clk,
    input  logic               rst,
    regfile_multiport_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic                clr_busy_q, clr_busy_d;
    logic                clr_done_q, clr_done_d;
    logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
    logic [XLEN-1:0]     regs_q [1:NREG-1];
    logic [XLEN-1:0]     regs_d [1:NREG-1];
    logic                wr_hit;

    // Address names a stored register (x0 and out-of-range are not stored).
    function automatic logic addr_valid(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < 32'(NREG));
    endfunction

    // Writes are dropped while the sequencer owns the storage.
    assign wr_hit = bus.wr_en && (state_q != CLEAR) && addr_valid(bus.wr_addr);

    // Clear sequencer; busy/done are derived from the next state so that the
    // outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = AW'(1);
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(NREG - 1)) begin
                    state_d = DONE;
                    ptr_d   = AW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        clr_busy_d = (state_d == CLEAR);
        clr_done_d = (state_d == DONE);
    end

    // Storage update: the clear pointer and a write can never coincide
    // because writes are blocked in CLEAR.
    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
            if ((state_q == CLEAR) && (ptr_q == AW'(r))) begin
                regs_d[r] = '0;
            end else if (wr_hit && (bus.wr_addr == AW'(r))) begin
                regs_d[r] = bus.wr_data;
            end
        end
    end

    // Read ports: a disabled port holds; x0 and unmapped addresses match no
    // stored register and therefore read as zero.
    always_comb begin
        rd_data_d = rd_data_q;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rd_en[i]) begin
                rd_data_d[i*XLEN +: XLEN] = '0;
                for (int r = 1; r < NREG; r++) begin
                    if (bus.rd_addr[i*AW +: AW] == AW'(r)) begin
                        rd_data_d[i*XLEN +: XLEN] = regs_q[r];
                    end
                end
`ifdef REGFILE_BYPASS_EN
                if ((state_q == CLEAR) && (ptr_q == bus.rd_addr[i*AW +: AW])) begin
                    rd_data_d[i*XLEN +: XLEN] = '0;
                end else if (wr_hit && (bus.wr_addr == bus.rd_addr[i*AW +: AW])) begin
                    rd_data_d[i*XLEN +: XLEN] = bus.wr_data;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= AW'(1);
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            rd_data_q  <= '0;
            for (int r = 1; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            rd_data_q  <= rd_data_d;
            for (int r = 1; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised integer register file for the RISC-V core. It provides NRD synchronous read ports and one write port with its own address. x0 is hardwired to zero. A hardware clear sequencer zeroes the whole file without a global reset. It replaces the fixed 32×32, 2-read, shared-address register unit between decode (read) and writeback (write).

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (2..2^AW)
- AW, 5, register address width
- NRD, 2, number of read ports (1..4)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- rd_en  input  NRD  per-port read enable; bit i gates port i
- rd_addr  input  NRD*AW  read addresses; port i at [i*AW +: AW]
- rd_data  output  NRD*XLEN  registered read data; port i at [i*XLEN +: XLEN]
- wr_en  input  1  write enable
- wr_addr  input  AW  write address
- wr_data  input  XLEN  write data
- clr_req  input  1  request a full-file clear; level-sampled in IDLE only
- clr_busy  output  1  clear in progress; writes ignored
- clr_done  output  1  one-cycle pulse when clear completes

## Operation
- Storage: registers 1..NREG-1, each XLEN bits. Register 0 is not stored.
- Reads: on each edge with rd_en[i]=1, rd_data port i <= reg[rd_addr_i]. With rd_en[i]=0, port i holds its value.
  - Address 0 returns 0.
  - Any address >= NREG returns 0.
- Writes: on an edge with wr_en=1 and clr_busy=0, reg[wr_addr] <= wr_data.
  - Writes to address 0 or to addresses >= NREG are discarded. This corrects the previous unit, which wrote into unused storage.
- Read/write to the same address in the same cycle: behaviour is set by REGFILE_BYPASS_EN (see Configuration).
- Clear FSM has three states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clr_req=1. The pointer ptr is loaded with 1.
  - In CLEAR, each edge does reg[ptr] <= 0 and ptr <= ptr+1. When ptr == NREG-1 (last register cleared), the FSM moves to DONE.
  - DONE -> IDLE unconditionally after one cycle.
- Outputs per state:
  - clr_busy=1 exactly in CLEAR.
  - clr_done=1 exactly in DONE.
- Clear-related rules:
  - clr_req is ignored in CLEAR and DONE; it is not queued.
  - clr_req together with wr_en in IDLE: the write completes on that edge, and the clear starts and later overwrites it.
  - While busy, wr_en is dropped silently. The upstream stage must stall on clr_busy.
  - Reads stay fully functional during a clear and return current contents (partially cleared).
- Reset: rst low, at any time including mid-clear, forces:
  - all registers = 0, rd_data = 0;
  - state IDLE, ptr = 1;
  - clr_busy = 0, clr_done = 0.

## Timing
- Read latency: 1 cycle. Address presented in cycle t gives data valid after edge t, visible in cycle t+1.
- Write: architecturally visible to a read issued in cycle t+1 or later.
- Clear: clr_req sampled high at edge t gives:
  - clr_busy high for NREG-1 cycles (cycles t+1 .. t+NREG-1);
  - clr_done high in cycle t+NREG;
  - writes accepted again from cycle t+NREG.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- REGFILE_BYPASS_EN defined: a same-cycle write-to-read match forwards the write data.
  - Match condition: rd_en[i], and a write or clear-write targeting rd_addr_i (address != 0, < NREG).
  - Result: rd_data port i receives wr_data, or 0 for a clear-write.
  - Used by the pipeline to avoid a writeback hazard stall.
- REGFILE_BYPASS_EN undefined: read-before-write; port i receives the old register value. No forwarding logic is built.

## Test plan
- Reset then read: pulse rst low, read x5 and x31 on two ports -> rd_data = 0 on both, clr_busy=0, clr_done=0.
- Write/read and x0:
  - write x7=0xDEADBEEF, then read x7 next cycle -> 0xDEADBEEF;
  - write x0=0x12345678, then read x0 -> 0x00000000.
- Same-cycle hazard: x3=0x11, then write x3=0x22 while reading x3 -> rd_data 0x22 with REGFILE_BYPASS_EN, 0x11 without. Read x3 again -> 0x22 in both builds.
- Clear sequence:
  - fill x1..x31 with values 0x100+n, then pulse clr_req -> clr_busy high exactly 31 cycles;
  - a write x9=0xAA during busy is dropped;
  - clr_done pulses once; all reads then return 0.
- Reset mid-clear: assert rst on busy cycle 10 -> clr_busy=0 immediately, all registers 0; a new clr_req runs the full 31 cycles.
- Parameters NRD=3, NREG=16: read address 20 -> 0; write address 17 is discarded; the three ports return independent values in the same cycle.
